// File: rtl/spi_adc_responder.sv
// SPI register-file responder: 16-bit frames, R/W + 7-bit address + data.
// Optional read-back path enabled by defining SPI_ADC_RESPONDER_READ_EN.
module spi_adc_responder #(
  parameter int              NREG    = 16,
  parameter logic [8*NREG-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              spi_cs_i,
  input  logic              spi_clk_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_t,
  output logic [8*NREG-1:0] regs_o,
  output logic              wr_stb_o,
  output logic [6:0]        wr_adr_o,
  output logic              frm_err_o
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [7:0] NREG_W = 8'(NREG);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT
  } state_t;

  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [6:0]  shreg_q;
  logic        rw_q;
  logic [6:0]  adr_q;
  logic [7:0]  regs_q [NREG];

  logic cs_s1, cs_s2, cs_s3;
  logic sclk_s1, sclk_s2, sclk_s3;
  logic mosi_s1, mosi_s2;

  logic cs_fall;
  logic cs_rise;
  logic sclk_rise;
  logic adr_ok;

  // CS resets low so a frame already in flight at reset release
  // never produces a falling edge; the next real frame must start.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_s3   <= 1'b0;
      sclk_s1 <= 1'b1;
      sclk_s2 <= 1'b1;
      sclk_s3 <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= spi_cs_i;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      sclk_s1 <= spi_clk_i;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= spi_mosi_i;
      mosi_s2 <= mosi_s1;
    end
  end

  assign cs_fall   = cs_s3 & ~cs_s2;
  assign cs_rise   = ~cs_s3 & cs_s2;
  assign sclk_rise = ~sclk_s3 & sclk_s2;
  assign adr_ok    = {1'b0, adr_q} < NREG_W;

  // Frame decoder, register file and write/abort strobes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      rw_q      <= 1'b0;
      adr_q     <= '0;
      wr_stb_o  <= 1'b0;
      wr_adr_o  <= '0;
      frm_err_o <= 1'b0;
      for (int n = 0; n < NREG; n++) begin
        regs_q[n] <= RST_VAL[8*n +: 8];
      end
    end else begin
      wr_stb_o  <= 1'b0;
      frm_err_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= ADDR;
            bit_cnt_q <= '0;
          end
        end
        ADDR: begin
          if (cs_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            frm_err_o <= 1'b1;
          end else if (sclk_rise) begin
            shreg_q   <= {shreg_q[5:0], mosi_s2};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_q <= DATA;
              rw_q    <= shreg_q[6];
              adr_q   <= {shreg_q[5:0], mosi_s2};
            end
          end
        end
        DATA: begin
          if (cs_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            frm_err_o <= 1'b1;
          end else if (sclk_rise) begin
            shreg_q   <= {shreg_q[5:0], mosi_s2};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              state_q   <= WAIT;
              bit_cnt_q <= '0;
              if (!rw_q && adr_ok) begin
                regs_q[adr_q[AW-1:0]] <= {shreg_q, mosi_s2};
                wr_stb_o <= 1'b1;
                wr_adr_o <= adr_q;
              end
            end
          end
        end
        WAIT: begin
          if (cs_rise) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_regs
    assign regs_o[8*g +: 8] = regs_q[g];
  end

`ifdef SPI_ADC_RESPONDER_READ_EN
  logic       sclk_fall;
  logic [6:0] rd_adr;
  logic [7:0] rd_byte;
  logic [7:0] miso_sh_q;
  logic       miso_q;
  logic       miso_t_q;
  logic       rd_load;
  logic       rd_end;

  assign sclk_fall = sclk_s3 & ~sclk_s2;
  assign rd_adr    = {shreg_q[5:0], mosi_s2};
  assign rd_byte   = ({1'b0, rd_adr} < NREG_W) ?
                     regs_q[rd_adr[AW-1:0]] : 8'h00;
  assign rd_load   = (state_q == ADDR) && !cs_rise && sclk_rise &&
                     (bit_cnt_q == 4'd7) && shreg_q[6];
  assign rd_end    = cs_rise || (sclk_rise && bit_cnt_q == 4'd15);

  // Read shifter: load at the address boundary, shift on SPI falls.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      miso_sh_q <= '0;
      miso_q    <= 1'b0;
      miso_t_q  <= 1'b1;
    end else if (rd_load) begin
      miso_sh_q <= rd_byte;
      miso_q    <= 1'b0;
      miso_t_q  <= 1'b0;
    end else if (state_q == DATA && !rd_end) begin
      if (sclk_fall && rw_q) begin
        miso_q    <= miso_sh_q[7];
        miso_sh_q <= {miso_sh_q[6:0], 1'b0};
      end
    end else begin
      miso_q   <= 1'b0;
      miso_t_q <= 1'b1;
    end
  end

  assign spi_miso_o = miso_q;
  assign spi_miso_t = miso_t_q;
`else
  assign spi_miso_o = 1'b0;
  assign spi_miso_t = 1'b1;
`endif

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder at 125 MHz / 12.5 MHz SPI.
// Read-back checks follow SPI_ADC_RESPONDER_READ_EN.
module tb_spi_adc_responder;

  localparam int NREG = 16;
  localparam logic [127:0] RV =
    128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
  localparam int HALF = 40;

  logic         clk;
  logic         rstn;
  logic         cs;
  logic         sclk;
  logic         mosi;
  logic         miso;
  logic         miso_t;
  logic [127:0] regs;
  logic         wr_stb;
  logic [6:0]   wr_adr;
  logic         frm_err;

  int n_cmp;
  int n_fail;
  int stb_cnt;
  int err_cnt;
  int mt_cnt;

  logic [127:0] exp_regs;

  spi_adc_responder #(
    .NREG   (NREG),
    .RST_VAL(RV)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .spi_cs_i  (cs),
    .spi_clk_i (sclk),
    .spi_mosi_i(mosi),
    .spi_miso_o(miso),
    .spi_miso_t(miso_t),
    .regs_o    (regs),
    .wr_stb_o  (wr_stb),
    .wr_adr_o  (wr_adr),
    .frm_err_o (frm_err)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Pulse monitors count high cycles, so a stretched pulse counts twice.
  always @(negedge clk) begin
    if (wr_stb) stb_cnt++;
    if (frm_err) err_cnt++;
    if (!miso_t) mt_cnt++;
  end

  task automatic spi_xfer(input logic [15:0] w, input int nbits,
                          output logic [15:0] rx);
    rx = '0;
    cs = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = (i < 16) ? w[15-i] : 1'b1;
      #(HALF);
      sclk = 1'b1;
      if (i < 16) rx[15-i] = miso;
      #(HALF);
    end
    cs = 1'b1;
    #(HALF*4);
  endtask

  task automatic test_reset;
    #20;
    n_cmp++;
    if (regs !== RV) begin
      $display("FAIL reset_regs got %h want %h", regs, RV);
      n_fail++;
    end
    n_cmp++;
    if ({wr_stb, frm_err, wr_adr} !== 9'd0) begin
      $display("FAIL reset_outs got %b%b %h want 0", wr_stb, frm_err, wr_adr);
      n_fail++;
    end
    n_cmp++;
    if ({miso, miso_t} !== 2'b01) begin
      $display("FAIL reset_miso got %b%b want 01", miso, miso_t);
      n_fail++;
    end
    rstn = 1'b1;
    #100;
  endtask

  task automatic test_write;
    logic [15:0] rx;
    int s0;
    s0 = stb_cnt;
    spi_xfer(16'h0302, 16, rx);
    exp_regs[31:24] = 8'h02;
    n_cmp++;
    if (regs !== exp_regs) begin
      $display("FAIL write_regs got %h want %h", regs, exp_regs);
      n_fail++;
    end
    n_cmp++;
    if (stb_cnt - s0 !== 1) begin
      $display("FAIL write_stb got %0d want 1", stb_cnt - s0);
      n_fail++;
    end
    n_cmp++;
    if (wr_adr !== 7'd3) begin
      $display("FAIL write_adr got %0d want 3", wr_adr);
      n_fail++;
    end
  endtask

  task automatic test_read;
    logic [15:0] rx;
    int s0;
    int m0;
    spi_xfer(16'h0201, 16, rx);
    exp_regs[23:16] = 8'h01;
    s0 = stb_cnt;
    m0 = mt_cnt;
    spi_xfer(16'h8200, 16, rx);
    n_cmp++;
    if (regs !== exp_regs || stb_cnt != s0) begin
      $display("FAIL read_side got %h stb %0d want %h stb 0",
               regs, stb_cnt - s0, exp_regs);
      n_fail++;
    end
`ifdef SPI_ADC_RESPONDER_READ_EN
    n_cmp++;
    if (rx[7:0] !== 8'h01) begin
      $display("FAIL read_data got %h want 01", rx[7:0]);
      n_fail++;
    end
    n_cmp++;
    if (mt_cnt == m0) begin
      $display("FAIL read_oe got 0 enabled cycles want >0");
      n_fail++;
    end
`else
    n_cmp++;
    if (rx !== 16'h0000) begin
      $display("FAIL read_miso got %h want 0000", rx);
      n_fail++;
    end
    n_cmp++;
    if (mt_cnt != m0) begin
      $display("FAIL read_oe got %0d enabled cycles want 0", mt_cnt - m0);
      n_fail++;
    end
`endif
  endtask

  task automatic test_abort;
    logic [15:0] rx;
    int s0;
    int e0;
    int m0;
    s0 = stb_cnt;
    e0 = err_cnt;
    m0 = mt_cnt;
    spi_xfer(16'h01FF, 11, rx);
    n_cmp++;
    if (regs !== exp_regs) begin
      $display("FAIL abort_regs got %h want %h", regs, exp_regs);
      n_fail++;
    end
    n_cmp++;
    if (err_cnt - e0 !== 1) begin
      $display("FAIL abort_err got %0d want 1", err_cnt - e0);
      n_fail++;
    end
    n_cmp++;
    if (stb_cnt != s0 || mt_cnt != m0) begin
      $display("FAIL abort_stb got stb %0d oe %0d want 0 0",
               stb_cnt - s0, mt_cnt - m0);
      n_fail++;
    end
  endtask

  task automatic test_out_of_range;
    logic [15:0] rx;
    int s0;
    int e0;
    s0 = stb_cnt;
    e0 = err_cnt;
    spi_xfer(16'h7FAA, 16, rx);
    n_cmp++;
    if (regs !== exp_regs) begin
      $display("FAIL oor_regs got %h want %h", regs, exp_regs);
      n_fail++;
    end
    n_cmp++;
    if (stb_cnt != s0 || err_cnt != e0) begin
      $display("FAIL oor_pulses got stb %0d err %0d want 0 0",
               stb_cnt - s0, err_cnt - e0);
      n_fail++;
    end
  endtask

  task automatic test_extra_bits;
    logic [15:0] rx;
    int s0;
    int e0;
    s0 = stb_cnt;
    e0 = err_cnt;
    spi_xfer(16'h0455, 20, rx);
    exp_regs[39:32] = 8'h55;
    n_cmp++;
    if (regs !== exp_regs) begin
      $display("FAIL extra_regs got %h want %h", regs, exp_regs);
      n_fail++;
    end
    n_cmp++;
    if (stb_cnt - s0 !== 1 || err_cnt != e0) begin
      $display("FAIL extra_pulses got stb %0d err %0d want 1 0",
               stb_cnt - s0, err_cnt - e0);
      n_fail++;
    end
    n_cmp++;
    if (wr_adr !== 7'd4) begin
      $display("FAIL extra_adr got %0d want 4", wr_adr);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] w;
    logic [15:0] rx;
    int s0;
    int e0;
    w = 16'h0BEE;
    s0 = stb_cnt;
    e0 = err_cnt;
    cs = 1'b0;
    #(HALF);
    for (int i = 0; i < 6; i++) begin
      sclk = 1'b0;
      mosi = w[15-i];
      #(HALF);
      sclk = 1'b1;
      #(HALF);
    end
    #3;
    rstn = 1'b0;
    #2;
    exp_regs = RV;
    n_cmp++;
    if (regs !== RV) begin
      $display("FAIL rst_mid_regs got %h want %h", regs, RV);
      n_fail++;
    end
    #30;
    rstn = 1'b1;
    for (int i = 6; i < 16; i++) begin
      sclk = 1'b0;
      mosi = w[15-i];
      #(HALF);
      sclk = 1'b1;
      #(HALF);
    end
    cs = 1'b1;
    #(HALF*4);
    n_cmp++;
    if (regs !== RV || stb_cnt != s0 || err_cnt != e0) begin
      $display("FAIL rst_partial got %h stb %0d err %0d want %h 0 0",
               regs, stb_cnt - s0, err_cnt - e0, RV);
      n_fail++;
    end
    spi_xfer(16'h0A5C, 16, rx);
    exp_regs[87:80] = 8'h5C;
    n_cmp++;
    if (regs !== exp_regs) begin
      $display("FAIL rst_next_regs got %h want %h", regs, exp_regs);
      n_fail++;
    end
    n_cmp++;
    if (stb_cnt - s0 !== 1 || wr_adr !== 7'd10) begin
      $display("FAIL rst_next_stb got stb %0d adr %0d want 1 10",
               stb_cnt - s0, wr_adr);
      n_fail++;
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    stb_cnt  = 0;
    err_cnt  = 0;
    mt_cnt   = 0;
    exp_regs = RV;
    rstn     = 1'b0;
    cs       = 1'b1;
    sclk     = 1'b1;
    mosi     = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_out_of_range();
    test_extra_bits();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_adc_responder.md
SPI_ADC_RESPONDER -- requirements
Module: spi_adc_responder

Interface
REQ-001 SHALL have parameter NREG, default 16, meaning the number of 8-bit registers in the register file (address space 0..NREG-1, NREG<=128).
REQ-002 SHALL have parameter [8*NREG-1:0] RST_VAL, default all zeros, meaning the per-register reset value (register n at bits 8n+7:8n).
REQ-003 SHALL have port clk_i, input, 1 bit: system clock; all logic is in this single clock domain.
REQ-004 SHALL have port rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port spi_cs_i, input, 1 bit: chip select, active low, asynchronous to clk_i.
REQ-006 SHALL have port spi_clk_i, input, 1 bit: SPI clock, idle high, asynchronous to clk_i.
REQ-007 SHALL have port spi_mosi_i, input, 1 bit: serial data from the master, MSB first.
REQ-008 SHALL have port spi_miso_o, output, 1 bit: serial read data to the master.
REQ-009 SHALL have port spi_miso_t, output, 1 bit: MISO tristate control, 1 = high-Z.
REQ-010 SHALL have port regs_o, output, 8*NREG bits: flattened register file contents.
REQ-011 SHALL have port wr_stb_o, output, 1 bit: one-cycle pulse on each register write commit.
REQ-012 SHALL have port wr_adr_o, output, 7 bits: address of the last write commit.
REQ-013 SHALL have port frm_err_o, output, 1 bit: one-cycle pulse when a frame is aborted.

Function
REQ-014 SHALL pass spi_cs_i, spi_clk_i and spi_mosi_i through 2-FF synchronizers, then detect edges on synchronized spi_clk_i by comparing against a third register.
REQ-015 SHALL require f(spi_clk_i) <= f(clk_i)/8 (12.5 MHz at 125 MHz is supported); behaviour at faster SPI clocks is undefined.
REQ-016 SHALL decode a 16-bit frame: bit 15 = R/W (1 = read), bits 14:8 = address, bits 7:0 = data; MOSI is sampled on the synchronized rising edge of spi_clk_i.
REQ-017 SHALL implement states IDLE, ADDR, DATA and WAIT: IDLE->ADDR when synchronized CS falls; ADDR->DATA after the 8th sampled bit; DATA->WAIT after the 16th sampled bit; WAIT->IDLE when CS rises.
REQ-018 SHALL, on a write frame with address < NREG, update the register and pulse wr_stb_o exactly one clk_i cycle after the 16th rising-edge detection, with wr_adr_o updated on the same cycle.
REQ-019 SHALL ignore write frames with address >= NREG: no register change, no wr_stb_o pulse.
REQ-020 SHALL ignore SPI clock edges in WAIT; extra bits beyond 16 have no effect.
REQ-021 SHALL, if CS rises in ADDR or DATA, discard the frame, change no register, pulse frm_err_o for one cycle, and return to IDLE.
REQ-022 SHALL treat a synchronized CS rise and an SPI clock edge in the same cycle as CS rise, with the edge discarded.
REQ-023 SHALL keep regs_o registered; it changes only on a write commit or reset.

Reset
REQ-024 SHALL, while rstn_i is low, asynchronously force the following: state = IDLE, bit counter = 0, regs_o = RST_VAL, wr_stb_o = 0, wr_adr_o = 0, frm_err_o = 0, spi_miso_o = 0, spi_miso_t = 1.
REQ-025 SHALL treat a reset mid-frame as a full abort with no frm_err_o pulse; after reset release, a frame is decoded only from the next CS falling edge.

Configuration
REQ-026 SHALL provide read support under macro SPI_ADC_RESPONDER_READ_EN.
- Defined: after the 8th rising edge of a read frame, load register[addr] (0x00 if addr >= NREG).
- Drive its MSB on the next synchronized falling edge, and shift one bit per subsequent falling edge.
- spi_miso_t = 0 in DATA of a read frame; 1 otherwise.
- Read frames do not modify registers.
REQ-027 SHALL, with SPI_ADC_RESPONDER_READ_EN undefined: tie spi_miso_o to 0 and spi_miso_t to 1; a read frame completes normally and has no side effects.

Verification
REQ-028 SHALL verify that a write frame 0x0302 (addr 3, data 0x02) at 12.5 MHz gives regs_o[31:24] = 0x02, one wr_stb_o pulse, and wr_adr_o = 3.
REQ-029 SHALL verify, with READ_EN defined, that preloading reg 2 = 0x01 and sending read frame 0x8200 returns MISO bits 0x01 on DATA rising edges and leaves regs unchanged.
REQ-030 SHALL verify that CS rising after 11 bits of write frame 0x01FF leaves reg 1 unchanged and produces one frm_err_o pulse and no wr_stb_o.
REQ-031 SHALL verify that write frame 0x7FAA with NREG = 16 produces no register change and no wr_stb_o.
REQ-032 SHALL verify that 20 clocks in one CS window carrying 0x0455 followed by 4 extra bits give reg 4 = 0x55 and exactly one wr_stb_o.
REQ-033 SHALL verify that asserting rstn_i low mid-frame returns regs_o to RST_VAL immediately, that the partial frame is lost, and that the next complete frame decodes correctly.
